// File: rtl/eth_wb_pkg.sv
// Shared types and register map for the Ethernet TX Wishbone arbiter.
// Imported by the arbiter top and its lock-tracking helper.
package eth_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FRAME = 2'd2
  } arb_state_t;

  localparam int REG_DATA      = 0;
  localparam int REG_LEN       = 1;
  localparam int REG_SEND      = 3;
  localparam int OUTST_MAX_DEF = 4;

endpackage

// File: rtl/eth_tx_arb_lock.sv
// Outstanding-beat counter, idle watchdog and pending-release tracking
// for a frame-locked grant.
module eth_tx_arb_lock
  import eth_wb_pkg::*;
#(
  parameter int OUTST_MAX    = OUTST_MAX_DEF,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic ack,
  input  logic owner_cyc,
  input  logic is_data_write,
  input  logic is_send_write,
  output logic rel,
  output logic timeout,
  output logic full,
  output logic empty
);

  localparam int OW = $clog2(OUTST_MAX + 1);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic [OW-1:0] outst;
  logic [OW-1:0] outst_nxt;
  logic [CW-1:0] idle_ctr;
  logic          open;
  logic          pend;
  logic          dec;

  // Stray acks with nothing outstanding are swallowed.
  assign dec       = ack & (outst != '0);
  assign outst_nxt = outst + OW'(accept) - OW'(dec);
  assign full      = (outst == OW'(OUTST_MAX));
  assign empty     = (outst == '0);
  assign timeout   = open & (idle_ctr == CW'(LOCK_TIMEOUT));
  assign rel       = open & pend & (outst_nxt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      outst    <= '0;
      idle_ctr <= '0;
      open     <= 1'b0;
      pend     <= 1'b0;
    end else if (timeout) begin
      outst    <= '0;
      idle_ctr <= '0;
      open     <= 1'b0;
      pend     <= 1'b0;
    end else begin
      outst <= outst_nxt;
      if (rel) begin
        idle_ctr <= '0;
        open     <= 1'b0;
        pend     <= 1'b0;
      end else begin
        if (is_data_write)
          open <= 1'b1;
        if (open && is_send_write)
          pend <= 1'b1;
        if (open && !owner_cyc)
          idle_ctr <= idle_ctr + CW'(1);
        else
          idle_ctr <= '0;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin, frame-locking arbiter sharing the Ethernet TX register
// port between two pipelined Wishbone masters.
module eth_tx_arbiter
  import eth_wb_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 8,
  parameter int DATA_ADDR    = REG_DATA,
  parameter int SEND_ADDR    = REG_SEND,
  parameter int OUTST_MAX    = OUTST_MAX_DEF,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  output logic              m0_ack,
  output logic              m0_stall,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  output logic              m1_ack,
  output logic              m1_stall,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data,
  input  logic              s_ack,
  input  logic              s_stall,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              locked,
  output logic              timeout_evt
);

  arb_state_t        state;
  logic              last;
  logic              own_cyc;
  logic              own_stb;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;
  logic              accept;
  logic              is_data;
  logic              is_send;
  logic              rel;
  logic              timeout;
  logic              full;
  logic              empty;

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    unique case (1'b1)
      grant[0]: begin
        own_cyc  = m0_cyc;
        own_stb  = m0_stb;
        own_we   = m0_we;
        own_addr = m0_addr;
        own_data = m0_data;
      end
      grant[1]: begin
        own_cyc  = m1_cyc;
        own_stb  = m1_stb;
        own_we   = m1_we;
        own_addr = m1_addr;
        own_data = m1_data;
      end
      default: ;
    endcase
  end

  assign s_cyc  = own_cyc;
  assign s_stb  = own_stb & ~full;
  assign s_we   = own_we;
  assign s_addr = own_addr;
  assign s_data = own_data;

  assign accept  = s_cyc & s_stb & ~s_stall;
  assign is_data = accept & s_we & (s_addr == ADDR_W'(DATA_ADDR));
  assign is_send = accept & s_we & (s_addr == ADDR_W'(SEND_ADDR));

  assign m0_ack   = grant[0] & s_ack;
  assign m1_ack   = grant[1] & s_ack;
  assign m0_stall = ~grant[0] | s_stall | full;
  assign m1_stall = ~grant[1] | s_stall | full;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  eth_tx_arb_lock #(
    .OUTST_MAX    (OUTST_MAX),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_lock (
    .clk           (clk),
    .rst           (rst),
    .accept        (accept),
    .ack           (s_ack),
    .owner_cyc     (own_cyc),
    .is_data_write (is_data),
    .is_send_write (is_send),
    .rel           (rel),
    .timeout       (timeout),
    .full          (full),
    .empty         (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= 2'b00;
      last        <= 1'b1;
      locked      <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (m0_cyc || m1_cyc) begin
            state <= S_BUSY;
            if (m0_cyc && (!m1_cyc || last))
              grant <= 2'b01;
            else
              grant <= 2'b10;
          end
        end
        S_BUSY: begin
          if (is_data) begin
            state  <= S_FRAME;
            locked <= 1'b1;
          end else if (!own_cyc && empty) begin
            state <= S_IDLE;
            grant <= 2'b00;
            last  <= grant[1];
          end
        end
        S_FRAME: begin
          // Abandoned frame: drop the owner, late acks then go nowhere.
          if (timeout) begin
            state       <= S_IDLE;
            grant       <= 2'b00;
            locked      <= 1'b0;
            last        <= grant[1];
            timeout_evt <= 1'b1;
          end else if (rel) begin
            state  <= S_IDLE;
            grant  <= 2'b00;
            locked <= 1'b0;
            last   <= grant[1];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: arbitration vector table plus
// scoreboarded frame, contention, backpressure, timeout and reset cases.
module tb_eth_tx_arbiter;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } beat_t;

  typedef struct {
    logic       c0;
    logic       c1;
    logic [1:0] g;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mcyc[2];
  logic       mstb[2];
  logic       mwe[2];
  logic [1:0] maddr[2];
  logic [7:0] mdata[2];
  logic       mack[2];
  logic       mstall[2];
  logic [7:0] mrdata[2];
  logic       s_cyc, s_stb, s_we;
  logic [1:0] s_addr;
  logic [7:0] s_data;
  logic       s_ack, s_stall;
  logic [7:0] s_rdata;
  logic [1:0] grant;
  logic       locked, timeout_evt;

  always #5 clk = ~clk;

  eth_tx_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .m0_cyc      (mcyc[0]),
    .m0_stb      (mstb[0]),
    .m0_we       (mwe[0]),
    .m0_addr     (maddr[0]),
    .m0_data     (mdata[0]),
    .m0_ack      (mack[0]),
    .m0_stall    (mstall[0]),
    .m0_rdata    (mrdata[0]),
    .m1_cyc      (mcyc[1]),
    .m1_stb      (mstb[1]),
    .m1_we       (mwe[1]),
    .m1_addr     (maddr[1]),
    .m1_data     (mdata[1]),
    .m1_ack      (mack[1]),
    .m1_stall    (mstall[1]),
    .m1_rdata    (mrdata[1]),
    .s_cyc       (s_cyc),
    .s_stb       (s_stb),
    .s_we        (s_we),
    .s_addr      (s_addr),
    .s_data      (s_data),
    .s_ack       (s_ack),
    .s_stall     (s_stall),
    .s_rdata     (s_rdata),
    .grant       (grant),
    .locked      (locked),
    .timeout_evt (timeout_evt)
  );

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t q0[$];
  beat_t q1[$];
  int    ackq[$];
  int    cyc_n = 0;
  int    ack_delay = 0;
  int    stall_left = 0;
  int    outst_b = 0;
  int    max_outst = 0;
  int    full_seen = 0;
  int    acc_n = 0;
  int    m1_acc = 0;
  int    bad_g = 0;
  bit    g_en = 0;
  logic [1:0] g_exp = 2'b00;
  bit    send_next = 0;
  logic  locked_after_send = 1'b0;
  vec_t  tv[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int m, input logic [1:0] a, input logic [7:0] d);
    beat_t b;
    b.a = a;
    b.d = d;
    if (m == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  // Slave model: programmable initial stall, fixed ack latency.
  always @(posedge clk) begin
    #1;
    cyc_n++;
    s_rdata = 8'(cyc_n * 7);
    s_ack = 1'b0;
    if (ackq.size() > 0 && ackq[0] <= cyc_n) begin
      s_ack = 1'b1;
      void'(ackq.pop_front());
    end
    s_stall = (stall_left > 0);
    if (stall_left > 0) stall_left--;
  end

  // Slave-side monitor and scoreboard.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      outst_b = 0;
    end else begin
      if (outst_b == 4 && grant != 2'b00) begin
        full_seen++;
        chk("full_stall", {s_stb, grant[0] ? mstall[0] : mstall[1]}, 2'b01);
      end
      if (g_en && grant !== g_exp) bad_g++;
      if (send_next) begin
        locked_after_send = locked;
        send_next = 0;
      end
      if (s_cyc && s_stb && !s_stall) begin
        if (grant[1] ? (q1.size() == 0) : (q0.size() == 0)) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected beat a=%0h d=%0h", s_addr, s_data);
        end else begin
          b = grant[1] ? q1.pop_front() : q0.pop_front();
          chk("sb_beat", {s_we, s_addr, s_data}, {1'b1, b.a, b.d});
        end
        ackq.push_back(cyc_n + 1 + ack_delay);
        outst_b++;
        acc_n++;
        if (grant == 2'b10) m1_acc++;
        if (s_we && s_addr == 2'd3) send_next = 1;
      end
      if (s_ack && outst_b > 0) outst_b--;
      if (outst_b > max_outst) max_outst = outst_b;
    end
  end

  task automatic xfer(input int m, input int n, input logic [1:0] a,
                      input logic [7:0] d0, input int gap);
    int sent, acks, t;
    bit acc;
    sent = 0;
    acks = 0;
    t = 0;
    mcyc[m] = 1'b1;
    mstb[m] = 1'b1;
    mwe[m] = 1'b1;
    maddr[m] = a;
    mdata[m] = d0;
    push(m, a, d0);
    while (acks < n && t < 3000) begin
      @(negedge clk);
      acc = mstb[m] && !mstall[m];
      if (mack[m]) acks++;
      if (acc) sent++;
      @(posedge clk);
      #1;
      t++;
      if (acc) begin
        if (sent < n) begin
          mdata[m] = d0 + 8'(sent);
          push(m, a, mdata[m]);
        end else begin
          mstb[m] = 1'b0;
        end
      end
    end
    if (acks < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL xfer_timeout m%0d acks %0d expected %0d", m, acks, n);
    end
    mcyc[m] = 1'b0;
    mstb[m] = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b0;
      mstb[i] = 1'b0;
      mwe[i] = 1'b0;
      maddr[i] = 2'd0;
      mdata[i] = 8'd0;
    end
    ack_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    ackq.delete();
    m1_acc = 0;
    acc_n = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w, drop_c, leak, acks_seen, n;
    bit acc;
    s_ack = 1'b0;
    s_stall = 1'b0;
    s_rdata = 8'd0;
    tv[0] = '{c0: 1'b1, c1: 1'b0, g: 2'b01};
    tv[1] = '{c0: 1'b1, c1: 1'b1, g: 2'b10};
    tv[2] = '{c0: 1'b1, c1: 1'b1, g: 2'b01};
    tv[3] = '{c0: 1'b0, c1: 1'b1, g: 2'b10};
    tv[4] = '{c0: 1'b0, c1: 1'b0, g: 2'b00};
    tv[5] = '{c0: 1'b1, c1: 1'b1, g: 2'b01};

    do_reset();
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_flags", {locked, timeout_evt, s_cyc, s_stb}, 4'b0000);
    chk("rst_resp", {mstall[0], mstall[1], mack[0], mack[1]}, 4'b1100);
    @(posedge clk);
    #1;

    // Arbitration table: one-cycle grant latency and round-robin ties.
    for (int i = 0; i < 6; i++) begin
      mcyc[0] = tv[i].c0;
      mcyc[1] = tv[i].c1;
      @(negedge clk);
      chk("tbl_latency", {grant, s_cyc}, 3'b000);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("tbl_grant", grant, tv[i].g);
      chk("tbl_scyc", s_cyc, tv[i].g != 2'b00);
      chk("tbl_stall", {mstall[0], mstall[1]}, {~tv[i].g[0], ~tv[i].g[1]});
      chk("tbl_rdata", {mrdata[0], mrdata[1]}, {s_rdata, s_rdata});
      @(posedge clk);
      #1;
      mcyc[0] = 1'b0;
      mcyc[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end

    // Single-master frame with cyc dropped between beats.
    do_reset();
    xfer(0, 1, 2'd0, 8'd0, 1);
    chk("t1_locked", locked, 1'b1);
    g_exp = 2'b01;
    g_en = 1;
    for (int i = 1; i < 60; i++) xfer(0, 1, 2'd0, 8'(i), 1);
    xfer(0, 1, 2'd1, 8'd63, 1);
    g_en = 0;
    locked_after_send = 1'b0;
    xfer(0, 1, 2'd3, 8'd0, 0);
    chk("t1_release", {grant, locked, mstall[0]}, 4'b0001);
    chk("t1_beats", acc_n, 62);
    chk("t1_grant_held", bad_g, 0);
    chk("t1_lock_on_send", locked_after_send, 1'b1);
    chk("t1_sb_empty", q0.size(), 0);

    // Contention straight after reset.
    do_reset();
    fork
      begin
        xfer(0, 3, 2'd0, 8'h10, 0);
        xfer(0, 1, 2'd3, 8'h00, 0);
        chk("t2_no_m1_beats", m1_acc, 0);
        chk("t2_idle", grant, 2'b00);
        @(posedge clk);
        #1;
        chk("t2_m1_grant", grant, 2'b10);
      end
      xfer(1, 1, 2'd1, 8'h80, 0);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("t2_first_grant", grant, 2'b01);
        chk("t2_m1_stall", mstall[1], 1'b1);
      end
    join
    chk("t2_sb_empty", q0.size() + q1.size(), 0);

    // Interleave attempt during long cyc gaps.
    do_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) xfer(0, 1, 2'd0, 8'(8'h20 + i), 10);
        xfer(0, 1, 2'd3, 8'h00, 0);
        chk("t3_no_interleave", m1_acc, 0);
      end
      begin
        repeat (15) @(posedge clk);
        #1;
        xfer(1, 2, 2'd1, 8'h90, 0);
      end
    join
    chk("t3_m1_beats", m1_acc, 2);
    chk("t3_sb_empty", q0.size() + q1.size(), 0);

    // Backpressure: initial stall then delayed acks.
    do_reset();
    ack_delay = 3;
    max_outst = 0;
    full_seen = 0;
    stall_left = 5;
    xfer(0, 8, 2'd0, 8'h40, 0);
    locked_after_send = 1'b0;
    xfer(0, 1, 2'd3, 8'h00, 0);
    chk("t4_max_outst", max_outst, 4);
    chk("t4_full_seen", full_seen != 0, 1'b1);
    chk("t4_lock_on_send", locked_after_send, 1'b1);
    chk("t4_release", {grant, locked}, 3'b000);
    chk("t4_sb_empty", q0.size(), 0);

    // Abandoned frame and forced release.
    do_reset();
    drop_c = 0;
    fork
      begin
        xfer(0, 5, 2'd0, 8'h60, 0);
        drop_c = cyc_n;
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        xfer(1, 1, 2'd1, 8'hA0, 0);
      end
      begin
        w = 0;
        @(negedge clk);
        while (!timeout_evt && w < 600) begin
          @(negedge clk);
          w++;
        end
        chk("t5_evt", timeout_evt, 1'b1);
        chk("t5_grant_none", {grant, locked}, 3'b000);
        chk("t5_m1_waited", m1_acc, 0);
        chk("t5_idle_len", (cyc_n - drop_c) >= 254 && (cyc_n - drop_c) <= 258, 1'b1);
        @(negedge clk);
        chk("t5_pulse", timeout_evt, 1'b0);
        chk("t5_regrant", grant, 2'b10);
      end
    join
    chk("t5_sb_empty", q0.size() + q1.size(), 0);

    // Reset with two beats outstanding inside a frame.
    do_reset();
    ack_delay = 20;
    mcyc[0] = 1'b1;
    mstb[0] = 1'b1;
    mwe[0] = 1'b1;
    maddr[0] = 2'd0;
    mdata[0] = 8'h50;
    push(0, 2'd0, 8'h50);
    n = 0;
    w = 0;
    while (n < 2 && w < 50) begin
      @(negedge clk);
      acc = mstb[0] && !mstall[0];
      if (acc) n++;
      @(posedge clk);
      #1;
      w++;
      if (acc) begin
        if (n < 2) begin
          mdata[0] = 8'h51;
          push(0, 2'd0, 8'h51);
        end else begin
          mstb[0] = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("t6_outst", outst_b, 2);
    chk("t6_locked", locked, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mcyc[0] = 1'b0;
    @(negedge clk);
    chk("t6_after_rst", {s_cyc, grant, locked}, 4'b0000);
    leak = 0;
    acks_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (mack[0] || mack[1] || timeout_evt) leak++;
      if (s_ack) acks_seen++;
      @(negedge clk);
    end
    chk("t6_no_ack_leak", leak, 0);
    chk("t6_late_acks", acks_seen, 2);
    chk("t6_sb_empty", q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet TX register port between two pipelined Wishbone masters.
- TX port register map: addr 0 = frame data FIFO, addr 1 = length, addr 3 = send command.
- Arbitration is round-robin. Once a master writes frame data, its grant is frame-locked until that master writes the send command. This stops bytes from two frames interleaving in the TX FIFO, even though masters drop cyc between beats.
- An idle timeout recovers the port from a master that abandons a frame.

Parameters:
- ADDR_W, 2, Wishbone address width.
- DATA_W, 8, Wishbone data width.
- DATA_ADDR, 0, address whose accepted write opens a frame lock.
- SEND_ADDR, 3, address whose accepted write closes a frame lock.
- OUTST_MAX, 4, maximum beats accepted but not yet acked.
- LOCK_TIMEOUT, 255, idle cycles in a locked frame before forced release.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 request
- m0_addr  in  ADDR_W  master 0 address
- m0_data  in  DATA_W  master 0 write data
- m0_ack, m0_stall  out  1 each  master 0 response
- m0_rdata  out  DATA_W  master 0 read data
- m1_*  same set as m0_*  master 1
- s_cyc, s_stb, s_we  out  1 each  slave request
- s_addr  out  ADDR_W  slave address
- s_data  out  DATA_W  slave write data
- s_ack, s_stall  in  1 each  slave response
- s_rdata  in  DATA_W  slave read data
- grant  out  2  one-hot owner; 00 = none
- locked  out  1  frame lock held
- timeout_evt  out  1  one-cycle pulse on forced release

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- After reset: state=S_IDLE, grant=00, last=1 (so m0 wins the first tie), outstanding=0, idle_ctr=0, timeout_evt=0.
- In S_IDLE: s_cyc=s_stb=0, m*_ack=0, m*_stall=1.
- Request fields (cyc, stb, we, addr, data) are muxed combinationally from the granted master to the slave; there is no added beat latency once granted.
- Non-granted master sees stall=1 and ack=0.
- Granted master sees stall = s_stall | (outstanding==OUTST_MAX); when that term is high, s_stb is also forced 0.
- s_rdata fans out to both m*_rdata unconditionally.
- s_ack routes to the granted master only.
- Accepted beat = s_cyc & s_stb & !s_stall.
- outstanding: +1 per accepted beat, -1 per s_ack; both in the same cycle leaves it unchanged. It never underflows; a stray ack at 0 is ignored.
- Grant takes one cycle: a request first seen in cycle N reaches the slave in cycle N+1.

State machine:
- S_IDLE:
  - If any m*_cyc, grant the requester. If both request, grant the master that is not `last`.
  - Go to S_BUSY.
- S_BUSY (unlocked):
  - Accepted write to DATA_ADDR -> S_FRAME, locked=1.
  - Granted cyc=0 and outstanding==0 -> S_IDLE, last<=owner.
- S_FRAME (locked):
  - A drop of granted cyc does not release the grant.
  - idle_ctr increments on each cycle with granted cyc=0 and clears when cyc=1.
  - Accepted write to SEND_ADDR sets a pending-release flag. When pending and outstanding==0, including the cycle the final ack arrives: -> S_IDLE, locked=0, last<=owner.
  - idle_ctr reaching LOCK_TIMEOUT: force S_IDLE, pulse timeout_evt, clear outstanding; late acks are dropped.
- Boundaries:
  - Write to SEND_ADDR while in S_BUSY (no frame open): forwarded, and no lock is taken.
  - A second write to DATA_ADDR inside S_FRAME does not restart the frame.
  - Reset mid-frame: the slave sees s_cyc=0 from the cycle after the reset edge. All counters clear. No timeout_evt.

Decomposition:
- Shared package eth_wb_pkg holds:
  - state encoding S_IDLE / S_BUSY / S_FRAME;
  - register addresses REG_DATA=0, REG_LEN=1, REG_SEND=3;
  - the OUTST_MAX default.
- One natural sub-module, eth_tx_arb_lock, owns:
  - the outstanding counter, idle_ctr and pending-release flag;
  - its inputs are accept, ack, owner-cyc, is_data_write and is_send_write;
  - its outputs are release, timeout and full.

Test Plan:
1. Single master frame: m0 writes 60 bytes at addr 0, len 63 at addr 1, 0 at addr 3, dropping cyc between beats. Required: all 62 beats reach the slave in order; grant=01 throughout; locked=1 from the first data accept until the final ack; then S_IDLE.
2. Contention: m0 and m1 raise cyc in the same cycle after reset. Required: grant=01 on the next cycle; m1 stall=1 with no slave beats until m0's send ack; then grant=10 one cycle after S_IDLE.
3. Interleave attempt: m1 requests mid m0 frame while m0 has 10-cycle cyc gaps. Required: no m1 beat reaches the slave before m0's addr-3 write is acked.
4. Slave backpressure: s_stall=1 for 5 cycles, then s_ack delayed 3 cycles per beat. Required: outstanding never exceeds 4; granted stall rises at outstanding=4; release waits for the last ack.
5. Abandoned frame: m0 writes 5 data beats, then holds cyc=0 for 255 cycles. Required: timeout_evt high for exactly one cycle; grant=00 on the next cycle; a pending m1 is granted the following cycle.
6. Reset in S_FRAME with outstanding=2. Required: s_cyc=0, grant=00, locked=0 the cycle after rst; acks arriving later are not forwarded to either master.
